// File: rtl/rds_pkg.sv
// Shared constants, block index encoding and the reference CRC for the RDS group serializer.
package rds_pkg;

  localparam logic [9:0] POLY  = 10'h1B9;
  localparam logic [9:0] OFS_A = 10'h0FC;
  localparam logic [9:0] OFS_B = 10'h198;
  localparam logic [9:0] OFS_C = 10'h168;
  localparam logic [9:0] OFS_D = 10'h1B4;

  typedef enum logic [1:0] {
    BLK_A = 2'd0,
    BLK_B = 2'd1,
    BLK_C = 2'd2,
    BLK_D = 2'd3
  } blk_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND
  } state_e;

  // Remainder of info(x)*x^10 divided by g(x), shifting the message in MSB first.
  function automatic logic [9:0] crc10(input logic [15:0] info);
    logic [9:0] r;
    logic       fb;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      fb = r[9] ^ info[i];
      r  = {r[8:0], 1'b0};
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  function automatic logic [9:0] blk_offset(input blk_e b);
    case (b)
      BLK_A:   return OFS_A;
      BLK_B:   return OFS_B;
      BLK_C:   return OFS_C;
      default: return OFS_D;
    endcase
  endfunction

endpackage

// File: rtl/rds_crc10.sv
// Combinational RDS checkword: 10-bit CRC of one info word XORed with the block offset.
module rds_crc10
  import rds_pkg::*;
(
  input  logic [15:0] info,
  input  logic [9:0]  offset,
  output logic [9:0]  check
);

  assign check = crc10(info) ^ offset;

endmodule

// File: rtl/rds_group_serializer.sv
// Serializes four 16-bit RDS info words into a 104-bit group, one bit per bit_tick.
// Define RDS_DIFF_EN to differentially encode bit_out.
module rds_group_serializer
  import rds_pkg::*;
(
  input  logic        clk_25m,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        bit_tick,
  output logic        group_req,
  input  logic        group_ack,
  input  logic [15:0] word_a,
  input  logic [15:0] word_b,
  input  logic [15:0] word_c,
  input  logic [15:0] word_d,
  output logic        bit_out,
  output logic        bit_strobe,
  output logic        group_start,
  output logic        underrun
);

  state_e           state;
  logic [3:0][15:0] in_words;
  logic [3:0][15:0] words_q;
  logic [3:0][15:0] next_q;
  logic             acked;
  blk_e             blk_q;
  logic [4:0]       bit_q;
  logic [25:0]      sh_q;

  logic             hs;
  logic [1:0]       ld_idx;
  logic [15:0]      ld_info;
  logic [9:0]       ld_ofs;
  logic [9:0]       ld_check;
  logic [25:0]      ld_block;
  logic             start_grp;
  logic             send_tick;
  logic             ld_blk;
  logic             last_bit;
  logic             raw_bit;
  logic             coded_bit;

  assign in_words = {word_d, word_c, word_b, word_a};
  assign hs       = group_req & group_ack;

  // A new group always loads block A; words acked on the same tick are used directly.
  always_comb begin
    ld_idx  = 2'd0;
    ld_info = hs ? word_a : words_q[0];
    if (state == ST_SEND) begin
      ld_idx  = 2'(blk_q) + 2'd1;
      ld_info = words_q[ld_idx];
    end
  end

  assign ld_ofs = blk_offset(blk_e'(ld_idx));

  rds_crc10 u_crc (
    .info   (ld_info),
    .offset (ld_ofs),
    .check  (ld_check)
  );

  assign ld_block  = {ld_info, ld_check};
  assign start_grp = bit_tick & ((state == ST_WAIT) | (state == ST_REQ));
  assign send_tick = bit_tick & (state == ST_SEND);
  assign ld_blk    = send_tick & (bit_q == 5'd26);
  assign last_bit  = send_tick & (blk_q == BLK_D) & (bit_q == 5'd25);
  assign raw_bit   = (start_grp | ld_blk) ? ld_block[25] : sh_q[25];

`ifdef RDS_DIFF_EN
  logic d_prev;

  // Differential state runs across group boundaries; only reset clears it.
  always_ff @(posedge clk_25m or negedge reset_n) begin
    if (!reset_n) begin
      d_prev <= 1'b0;
    end else if (start_grp | send_tick) begin
      d_prev <= coded_bit;
    end
  end

  assign coded_bit = raw_bit ^ d_prev;
`else
  assign coded_bit = raw_bit;
`endif

  always_ff @(posedge clk_25m or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      group_req   <= 1'b0;
      bit_out     <= 1'b0;
      bit_strobe  <= 1'b0;
      group_start <= 1'b0;
      underrun    <= 1'b0;
      words_q     <= '0;
      next_q      <= '0;
      acked       <= 1'b0;
      blk_q       <= BLK_A;
      bit_q       <= 5'd0;
      sh_q        <= '0;
    end else begin
      bit_strobe  <= 1'b0;
      group_start <= 1'b0;
      underrun    <= 1'b0;

      if (start_grp | send_tick) begin
        bit_out    <= coded_bit;
        bit_strobe <= 1'b1;
      end

      if (start_grp) begin
        blk_q       <= BLK_A;
        bit_q       <= 5'd1;
        sh_q        <= {ld_block[24:0], 1'b0};
        group_start <= 1'b1;
      end else if (ld_blk) begin
        blk_q <= blk_e'(ld_idx);
        bit_q <= 5'd1;
        sh_q  <= {ld_block[24:0], 1'b0};
      end else if (send_tick) begin
        bit_q <= bit_q + 5'd1;
        sh_q  <= {sh_q[24:0], 1'b0};
      end

      case (state)
        ST_IDLE: begin
          bit_out <= 1'b0;
          if (enable) begin
            state     <= ST_REQ;
            group_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (hs) begin
            words_q   <= in_words;
            group_req <= 1'b0;
          end else if (bit_tick) begin
            underrun  <= 1'b1;
          end
          if (bit_tick)  state <= ST_SEND;
          else if (hs)   state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bit_tick) state <= ST_SEND;
        end
        ST_SEND: begin
          // Words acked mid-group are parked so the group on air stays intact.
          if (hs) begin
            next_q    <= in_words;
            acked     <= 1'b1;
            group_req <= 1'b0;
          end
          if (last_bit) begin
            if (acked | hs) words_q <= hs ? in_words : next_q;
            acked <= 1'b0;
            if (!enable) begin
              state     <= ST_IDLE;
              group_req <= 1'b0;
            end else if (acked | hs) begin
              state <= ST_WAIT;
            end else begin
              state     <= ST_REQ;
              group_req <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rds_group_serializer.sv
// Randomized bench for rds_group_serializer with a group-level reference model.
module tb_rds_group_serializer;

  logic        clk_25m   = 1'b0;
  logic        reset_n   = 1'b0;
  logic        enable    = 1'b0;
  logic        bit_tick  = 1'b0;
  logic        group_ack = 1'b0;
  logic [15:0] word_a = '0, word_b = '0, word_c = '0, word_d = '0;
  logic        group_req, bit_out, bit_strobe, group_start, underrun;

  int vectors     = 0;
  int miscompares = 0;

  rds_group_serializer dut (
    .clk_25m     (clk_25m),
    .reset_n     (reset_n),
    .enable      (enable),
    .bit_tick    (bit_tick),
    .group_req   (group_req),
    .group_ack   (group_ack),
    .word_a      (word_a),
    .word_b      (word_b),
    .word_c      (word_c),
    .word_d      (word_d),
    .bit_out     (bit_out),
    .bit_strobe  (bit_strobe),
    .group_start (group_start),
    .underrun    (underrun)
  );

  always #20 clk_25m = ~clk_25m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC by polynomial long division with the full 11-bit generator.
  function automatic logic [9:0] ref_crc(input logic [15:0] info);
    logic [25:0] v;
    v = {info, 10'd0};
    for (int i = 25; i >= 10; i--)
      if (v[i]) v = v ^ (26'h5B9 << (i - 10));
    return v[9:0];
  endfunction

  function automatic logic [9:0] ofs(input int b);
    case (b)
      0:       return 10'h0FC;
      1:       return 10'h198;
      2:       return 10'h168;
      default: return 10'h1B4;
    endcase
  endfunction

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_REQ, M_WAIT, M_SEND} mmode_e;
  mmode_e      m_mode = M_IDLE;
  logic [15:0] m_lat  [4];
  logic [15:0] m_pend [4];
  logic [15:0] m_cur  [4];
  logic        m_pend_v = 1'b0;
  logic        m_grp  [104];
  int          m_idx  = 0;
  logic        m_hs;
  logic        e_req = 1'b0, e_bit = 1'b0, e_stb = 1'b0, e_gs = 1'b0, e_ur = 1'b0;
`ifdef RDS_DIFF_EN
  logic        m_d = 1'b0;
`endif

  task automatic load_group();
    for (int b = 0; b < 4; b++) begin
      logic [25:0] blk;
      blk = {m_lat[b], ref_crc(m_lat[b]) ^ ofs(b)};
      for (int i = 0; i < 26; i++) m_grp[b*26 + i] = blk[25 - i];
    end
    m_idx = 0;
  endtask

  task automatic emit();
    logic raw;
    raw = m_grp[m_idx];
`ifdef RDS_DIFF_EN
    e_bit = raw ^ m_d;
    m_d   = e_bit;
`else
    e_bit = raw;
`endif
    e_stb = 1'b1;
    e_gs  = (m_idx == 0);
    m_idx++;
  endtask

  initial forever begin
    @(posedge clk_25m or negedge reset_n);
    if (!reset_n) begin
      m_mode = M_IDLE; e_req = 0; e_bit = 0; e_stb = 0; e_gs = 0; e_ur = 0;
      m_pend_v = 0; m_idx = 0;
`ifdef RDS_DIFF_EN
      m_d = 0;
`endif
      for (int b = 0; b < 4; b++) begin m_lat[b] = '0; m_pend[b] = '0; end
    end else begin
      m_hs = e_req & group_ack;
      m_cur[0] = word_a; m_cur[1] = word_b; m_cur[2] = word_c; m_cur[3] = word_d;
      e_stb = 0; e_gs = 0; e_ur = 0;
      case (m_mode)
        M_IDLE: begin
          e_bit = 0;
          if (enable) begin m_mode = M_REQ; e_req = 1; end
        end
        M_REQ: begin
          if (m_hs) begin m_lat = m_cur; e_req = 0; end
          if (bit_tick) begin
            if (!m_hs) e_ur = 1;
            load_group(); emit(); m_mode = M_SEND;
          end else if (m_hs) m_mode = M_WAIT;
        end
        M_WAIT: if (bit_tick) begin load_group(); emit(); m_mode = M_SEND; end
        M_SEND: begin
          if (m_hs) begin m_pend = m_cur; m_pend_v = 1; e_req = 0; end
          if (bit_tick) begin
            emit();
            if (m_idx == 104) begin
              if (m_pend_v) m_lat = m_pend;
              if (!enable) begin m_mode = M_IDLE; e_req = 0; end
              else if (m_pend_v) m_mode = M_WAIT;
              else begin m_mode = M_REQ; e_req = 1; end
              m_pend_v = 0;
            end
          end
        end
      endcase
    end
  end

  // ---------------- compare and capture ----------------
  logic cap [104];
  int   cap_n  = 0;
  int   gs_cnt = 0;
  int   ur_cnt = 0;
`ifdef RDS_DIFF_EN
  logic last_out = 1'b0, start_prev = 1'b0;
`endif

  initial forever begin
    @(negedge clk_25m);
    check("cycle outputs {req,bit,stb,gs,ur}",
          32'({group_req, bit_out, bit_strobe, group_start, underrun}),
          32'({e_req, e_bit, e_stb, e_gs, e_ur}));
`ifdef RDS_DIFF_EN
    if (!reset_n) last_out = 1'b0;
`endif
    if (bit_strobe === 1'b1) begin
      if (group_start === 1'b1) begin
`ifdef RDS_DIFF_EN
        start_prev = last_out;
`endif
        cap_n = 0;
        gs_cnt++;
      end
      if (cap_n < 104) cap[cap_n] = bit_out;
      cap_n++;
`ifdef RDS_DIFF_EN
      last_out = bit_out;
`endif
    end
    if (underrun === 1'b1) ur_cnt++;
  end

  function automatic logic raw_at(input int i);
`ifdef RDS_DIFF_EN
    return cap[i] ^ ((i == 0) ? start_prev : cap[i-1]);
`else
    return cap[i];
`endif
  endfunction

  function automatic logic [15:0] raw_field(input int start, input int len);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v = {v[14:0], raw_at(start + i)};
    return v;
  endfunction

  // ---------------- stimulus drivers ----------------
  int ack_pct   = 100;
  bit ack_en    = 1'b0;
  bit word_rand = 1'b0;

  initial forever begin
    repeat ($urandom_range(3, 8)) @(posedge clk_25m);
    #1 bit_tick = 1'b1;
    @(posedge clk_25m);
    #1 bit_tick = 1'b0;
  end

  initial forever begin
    @(posedge clk_25m);
    #1;
    group_ack = ack_en && group_req && ($urandom_range(0, 99) < ack_pct);
    if (word_rand) begin
      word_a = 16'($urandom); word_b = 16'($urandom);
      word_c = 16'($urandom); word_d = 16'($urandom);
    end
  end

  task automatic do_reset();
    @(posedge clk_25m);
    #5 reset_n = 1'b0;
    #1 check("reset outputs", 32'({group_req, bit_out, bit_strobe, group_start, underrun}), 32'd0);
    repeat (3) @(posedge clk_25m);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_gs(input int target, input int budget);
    int n;
    n = 0;
    while (gs_cnt < target && n < budget) begin @(posedge clk_25m); n++; end
    check("wait group_start", 32'(gs_cnt >= target), 32'd1);
    #1;
  endtask

  task automatic wait_cap(input int target, input int budget);
    int n;
    n = 0;
    while (cap_n < target && n < budget) begin @(posedge clk_25m); n++; end
    check("wait strobes", 32'(cap_n >= target), 32'd1);
    #1;
  endtask

  task automatic set_words(input logic [15:0] a, b, c, d);
    word_a = a; word_b = b; word_c = c; word_d = d;
  endtask

  initial begin
    int g0, u0;
    bit seen;

    check("ref crc 0x0000", 32'(ref_crc(16'h0000)), 32'h000);
    check("ref crc 0x0001", 32'(ref_crc(16'h0001)), 32'h1B9);
    check("ref chk A 0x0001", 32'(ref_crc(16'h0001) ^ ofs(0)), 32'h145);

    // All-zero words: checkwords are the bare offsets.
    do_reset();
    word_rand = 0; set_words(16'h0, 16'h0, 16'h0, 16'h0);
    ack_pct = 100; ack_en = 1; enable = 1;
    g0 = gs_cnt;
    wait_gs(g0 + 1, 300);
    ack_en = 0;
    wait_cap(104, 2000);
    check("T1 req after group", 32'(group_req), 32'd1);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("T1 info blk%0d", b), 32'(raw_field(b*26, 16)), 32'h0);
      check($sformatf("T1 check blk%0d", b), 32'(raw_field(b*26 + 16, 10)), 32'(ofs(b)));
    end
    @(posedge clk_25m); #1;
    check("T1 strobe count", 32'(cap_n), 32'd104);
    enable = 0;

    // Single-bit info word in block A.
    do_reset();
    set_words(16'h0001, 16'h0, 16'h0, 16'h0);
    ack_en = 1; enable = 1;
    g0 = gs_cnt;
    wait_gs(g0 + 1, 300);
    ack_en = 0;
    wait_cap(52, 1200);
    check("T2 info A", 32'(raw_field(0, 16)), 32'h0001);
    check("T2 check A", 32'(raw_field(16, 10)), 32'h145);
    check("T2 check B", 32'(raw_field(42, 10)), 32'h198);
    enable = 0;

    // Missing ack: one underrun, resend, then new words on the following group.
    do_reset();
    word_rand = 1; ack_pct = 100; ack_en = 1; enable = 1;
    g0 = gs_cnt; u0 = ur_cnt;
    wait_gs(g0 + 1, 300);
    ack_en = 0;
    wait_gs(g0 + 2, 3000);
    check("T4 one underrun", 32'(ur_cnt - u0), 32'd1);
    check("T4 req held", 32'(group_req), 32'd1);
    repeat (20) @(posedge clk_25m);
    #1 ack_pct = 30; ack_en = 1;
    wait_gs(g0 + 3, 3000);
    check("T4 no second underrun", 32'(ur_cnt - u0), 32'd1);

    // Dropping enable mid-group finishes the group, then idles.
    do_reset();
    ack_pct = 100; ack_en = 1; enable = 1;
    g0 = gs_cnt;
    wait_gs(g0 + 1, 300);
    wait_cap(30, 600);
    enable = 0;
    wait_cap(104, 1500);
    repeat (60) @(posedge clk_25m);
    #1;
    check("T5 bit_out idle", 32'(bit_out), 32'd0);
    check("T5 no req", 32'(group_req), 32'd0);
    check("T5 no new group", 32'(gs_cnt - g0), 32'd1);
    check("T5 full group", 32'(cap_n), 32'd104);

    // Asynchronous reset in block C, then restart from block A.
    word_rand = 0; set_words(16'hC0DE, 16'h1234, 16'hA5A5, 16'hFFFF);
    enable = 1;
    g0 = gs_cnt;
    wait_gs(g0 + 1, 300);
    wait_cap(62, 1000);
    #7 reset_n = 1'b0;
    #1 check("T6 async reset outputs", 32'({group_req, bit_out, bit_strobe, group_start, underrun}), 32'd0);
    repeat (2) @(posedge clk_25m);
    #1 reset_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk_25m); #1;
      if (group_req) seen = 1;
    end
    check("T6 req after reset", 32'(seen), 32'd1);
    wait_gs(g0 + 2, 300);
    wait_cap(26, 600);
    check("T6 restart info A", 32'(raw_field(0, 16)), 32'hC0DE);
    check("T6 restart check A", 32'(raw_field(16, 10)), 32'(ref_crc(16'hC0DE) ^ 10'h0FC));

    // Random soak with sporadic acks, underruns and an enable pause.
    do_reset();
    word_rand = 1; ack_pct = 20; ack_en = 1; enable = 1;
    for (int k = 0; k < 8; k++) begin
      ack_en = ($urandom_range(0, 3) != 0);
      wait_gs(gs_cnt + 1, 3000);
    end
    ack_en = 1;
    wait_cap(50, 1500);
    enable = 0;
    repeat (1200) @(posedge clk_25m);
    #1 enable = 1;
    wait_gs(gs_cnt + 1, 3000);
    wait_gs(gs_cnt + 1, 3000);
    enable = 0;
    repeat (10) @(posedge clk_25m);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_600_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
